data_sram_bridge: RTL and testbench

- Converts the datapath's single-cycle M-stage data access into the two-phase SRAM-like bus: req/addr_ok, then data_ok.
- Inputs are the datapath's M-stage outputs: data_sram_enM, memwrite_filterdM, aluoutM, writedataExtendedM.
- Returns read data to the datapath and produces a stall the hazard unit ORs into its global stall.
- Sits between the datapath and the memory-side interconnect; issues at most one bus transaction per M-stage instruction.

---
 rtl/data_sram_bridge_pkg.sv | 30 +++
 rtl/sram_req_latch.sv | 39 +++
 rtl/data_sram_bridge.sv | 141 ++++++++++++++
 tb/tb_data_sram_bridge.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_bridge_pkg.sv
// Shared definitions for the SRAM-like bus bridges (data side now, inst side later).
//   br_state_e      : bridge FSM states, also exported on the debug state port
//   SIZE_B/H/W      : bus data_size codes (byte, half, word)
//   sizeFromStrobe  : maps store byte strobes to a data_size code
package data_sram_bridge_pkg;

  typedef enum logic [1:0] {
    BR_IDLE = 2'd0,
    BR_REQ  = 2'd1,
    BR_WAIT = 2'd2,
    BR_DONE = 2'd3
  } br_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Full-word strobes give word, aligned half strobes give half and a single
  // lane gives byte. Other patterns cannot come out of the store filter.
  function automatic logic [1:0] sizeFromStrobe(input logic [3:0] wen);
    logic [1:0] size;
    case (wen)
      4'b1111:          size = SIZE_W;
      4'b0011, 4'b1100: size = SIZE_H;
      default:          size = SIZE_B;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/sram_req_latch.sv
// Holds the request fields of an issued bus transaction so that address,
// size, direction and write data stay stable while the request waits for
// addr_ok, even if the live M-stage values move.
//   clk, resetn  : clock, synchronous active-low reset
//   capture      : load the issue* fields this cycle
//   issue*       : live request fields at issue time
//   held*        : registered copy presented while the request is open
module sram_req_latch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              capture,
  input  logic [ADDR_W-1:0] issueAddr,
  input  logic [1:0]        issueSize,
  input  logic              issueWr,
  input  logic [DATA_W-1:0] issueWdata,
  output logic [ADDR_W-1:0] heldAddr,
  output logic [1:0]        heldSize,
  output logic              heldWr,
  output logic [DATA_W-1:0] heldWdata
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      heldAddr  <= '0;
      heldSize  <= '0;
      heldWr    <= 1'b0;
      heldWdata <= '0;
    end else if (capture) begin
      heldAddr  <= issueAddr;
      heldSize  <= issueSize;
      heldWr    <= issueWr;
      heldWdata <= issueWdata;
    end
  end

endmodule

// File: rtl/data_sram_bridge.sv
// Turns the single-cycle M-stage data access into a two-phase SRAM-like bus
// transaction (req/addr_ok, then data_ok) and stalls the pipeline until the
// access completes.
//   cpu_*    : M-stage access request, kill/flush, external stall; load data and stall out
//   data_*   : SRAM-like bus master side
//   dbgState : current FSM state
// Handshake: a request is transferred on a cycle where data_req and
// data_addr_ok are both high; once raised, data_req and its fields hold until
// that cycle. The response is the single data_data_ok pulse that follows (it
// may coincide with the accepting cycle). data_data_ok with no accepted
// request outstanding is ignored.
module data_sram_bridge
  import data_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_wen,
  input  logic [1:0]        cpu_rsize,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_kill,
  input  logic              cpu_other_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output br_state_e         dbgState
);

  br_state_e         state, stateNext;
  logic [DATA_W-1:0] rdataQ;
  logic              rdataLoad;
  logic              issue;
  logic              liveWr;
  logic [1:0]        liveSize;
  logic [ADDR_W-1:0] heldAddr;
  logic [1:0]        heldSize;
  logic              heldWr;
  logic [DATA_W-1:0] heldWdata;

  assign liveWr   = |cpu_wen;
  assign liveSize = liveWr ? sizeFromStrobe(cpu_wen) : cpu_rsize;

  // A fresh request only starts from IDLE; DONE must not re-issue the
  // instruction it has just completed while the pipeline is still held.
  assign issue = resetn & (state == BR_IDLE) & cpu_en & ~cpu_kill;

  sram_req_latch #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_req_latch (
    .clk       (clk),
    .resetn    (resetn),
    .capture   (issue),
    .issueAddr (cpu_addr),
    .issueSize (liveSize),
    .issueWr   (liveWr),
    .issueWdata(cpu_wdata),
    .heldAddr  (heldAddr),
    .heldSize  (heldSize),
    .heldWr    (heldWr),
    .heldWdata (heldWdata)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= BR_IDLE;
      rdataQ <= '0;
    end else begin
      state <= stateNext;
      if (rdataLoad) rdataQ <= data_rdata;
    end
  end

  // Completion while another source holds the pipeline parks in DONE with
  // the read data captured, since the bus data is only valid for one cycle.
  always_comb begin
    stateNext = state;
    rdataLoad = 1'b0;
    case (state)
      BR_IDLE: begin
        if (issue) begin
          if (!data_addr_ok)          stateNext = BR_REQ;
          else if (!data_data_ok)     stateNext = BR_WAIT;
          else if (cpu_other_stall) begin
            stateNext = BR_DONE;
            rdataLoad = 1'b1;
          end
        end
      end
      BR_REQ: begin
        if (data_addr_ok) begin
          if (!data_data_ok)          stateNext = BR_WAIT;
          else if (cpu_other_stall) begin
            stateNext = BR_DONE;
            rdataLoad = 1'b1;
          end else                    stateNext = BR_IDLE;
        end
      end
      BR_WAIT: begin
        if (data_data_ok) begin
          if (cpu_other_stall) begin
            stateNext = BR_DONE;
            rdataLoad = 1'b1;
          end else                    stateNext = BR_IDLE;
        end
      end
      BR_DONE: begin
        if (!cpu_other_stall)         stateNext = BR_IDLE;
      end
      default:                        stateNext = BR_IDLE;
    endcase
  end

  // In IDLE the request is driven straight from the live M-stage values so
  // a zero-wait bus completes in the issue cycle; in REQ the latched copy is used.
  assign data_req   = issue | (resetn & (state == BR_REQ));
  assign data_addr  = (state == BR_REQ) ? heldAddr  : cpu_addr;
  assign data_size  = (state == BR_REQ) ? heldSize  : liveSize;
  assign data_wr    = (state == BR_REQ) ? heldWr    : liveWr;
  assign data_wdata = (state == BR_REQ) ? heldWdata : cpu_wdata;

  assign cpu_stall = resetn & (
                       ((state == BR_IDLE) & cpu_en & ~cpu_kill & ~(data_addr_ok & data_data_ok))
                     | (state == BR_REQ)
                     | ((state == BR_WAIT) & ~data_data_ok));

  assign cpu_rdata = (state == BR_DONE) ? rdataQ : data_rdata;
  assign dbgState  = state;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Bench for data_sram_bridge: directed vectors with hand-computed checks plus
// a transaction-level model compared against the DUT every cycle.
module tb_data_sram_bridge;
  import data_sram_bridge_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn;
  always #5 clk = ~clk;

  logic        cpu_en, cpu_kill, cpu_other_stall;
  logic [3:0]  cpu_wen;
  logic [1:0]  cpu_rsize;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  br_state_e   dbgState;

  data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .cpu_en         (cpu_en),
    .cpu_wen        (cpu_wen),
    .cpu_rsize      (cpu_rsize),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_kill       (cpu_kill),
    .cpu_other_stall(cpu_other_stall),
    .cpu_rdata      (cpu_rdata),
    .cpu_stall      (cpu_stall),
    .data_req       (data_req),
    .data_wr        (data_wr),
    .data_size      (data_size),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_addr_ok   (data_addr_ok),
    .data_data_ok   (data_data_ok),
    .data_rdata     (data_rdata),
    .dbgState       (dbgState)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int   nCompared   = 0;
  int   nMismatched = 0;
  logic simDone     = 1'b0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: a request may be open (not yet accepted), owed (accepted,
  // waiting for data) or held (finished while the pipeline is stalled elsewhere).
  logic        mOpen = 1'b0, mOwed = 1'b0, mHeld = 1'b0;
  logic [31:0] mHeldData = '0, mAddr = '0, mWdata = '0;
  logic        mWr = 1'b0;
  logic [1:0]  mSize = '0;

  function automatic logic [1:0] expSize(input logic [3:0] wen, input logic [1:0] rsize);
    if (wen == 4'b0000) return rsize;
    case (wen)
      4'b1111:                            return 2'd2;
      4'b0011, 4'b1100:                   return 2'd1;
      default:                            return 2'd0;
    endcase
  endfunction

  task automatic modelComplete();
    if (cpu_other_stall) begin
      mHeld     = 1'b1;
      mHeldData = data_rdata;
    end
  endtask

  // Compare on the falling edge (inputs were driven 1 ns after the rising
  // edge), then advance the model with the inputs the next rising edge sees.
  initial begin
    logic       fresh, eReq, eStall;
    logic [1:0] eState;
    @(posedge clk);
    while (!simDone) begin
      @(negedge clk);
      if (!simDone) begin
        fresh  = resetn && !mOpen && !mOwed && !mHeld && cpu_en && !cpu_kill;
        eReq   = fresh || (resetn && mOpen);
        eStall = resetn && ((fresh && !(data_addr_ok && data_data_ok)) || mOpen ||
                            (mOwed && !data_data_ok));
        eState = mHeld ? BR_DONE : mOpen ? BR_REQ : mOwed ? BR_WAIT : BR_IDLE;
        exp_q.push_back(mHeld ? mHeldData : data_rdata);
        chk("mdl_req",   32'(data_req),  32'(eReq));
        chk("mdl_stall", 32'(cpu_stall), 32'(eStall));
        chk("mdl_rdata", cpu_rdata, exp_q.pop_front());
        chk("mdl_state", 32'(dbgState),  32'(eState));
        if (eReq) begin
          chk("mdl_addr",  data_addr,       mOpen ? mAddr  : cpu_addr);
          chk("mdl_wdata", data_wdata,      mOpen ? mWdata : cpu_wdata);
          chk("mdl_wr",    32'(data_wr),    32'(mOpen ? mWr : (cpu_wen != 4'b0000)));
          chk("mdl_size",  32'(data_size),  32'(mOpen ? mSize : expSize(cpu_wen, cpu_rsize)));
        end
        if (!resetn) begin
          mOpen = 1'b0; mOwed = 1'b0; mHeld = 1'b0; mHeldData = '0;
        end else if (mHeld) begin
          if (!cpu_other_stall) mHeld = 1'b0;
        end else if (mOpen) begin
          if (data_addr_ok) begin
            mOpen = 1'b0;
            if (data_data_ok) modelComplete();
            else              mOwed = 1'b1;
          end
        end else if (mOwed) begin
          if (data_data_ok) begin
            mOwed = 1'b0;
            modelComplete();
          end
        end else if (fresh) begin
          mAddr  = cpu_addr;
          mWdata = cpu_wdata;
          mWr    = (cpu_wen != 4'b0000);
          mSize  = expSize(cpu_wen, cpu_rsize);
          if (!data_addr_ok)      mOpen = 1'b1;
          else if (!data_data_ok) mOwed = 1'b1;
          else                    modelComplete();
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    cpu_en = 1'b0; cpu_kill = 1'b0; cpu_other_stall = 1'b0;
    cpu_wen = 4'b0000; cpu_rsize = 2'd0; cpu_addr = '0; cpu_wdata = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
  endtask

  task automatic access(input logic [3:0] wen, input logic [1:0] rsize,
                        input logic [31:0] addr, input logic [31:0] wdata);
    cpu_en = 1'b1; cpu_wen = wen; cpu_rsize = rsize; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  logic [3:0] vecWen   [5] = '{4'b0001, 4'b1111, 4'b0000, 4'b0100, 4'b0011};
  logic [1:0] vecRsize [5] = '{2'd0,    2'd0,    2'd1,    2'd0,    2'd0};
  logic [1:0] vecSize  [5] = '{2'd0,    2'd2,    2'd1,    2'd0,    2'd1};

  // ---------------- directed stimulus ----------------
  initial begin
    int stallCnt;
    resetn = 1'b0;
    idleInputs();
    tick();
    tick();
    #2;
    chk("rst_state", 32'(dbgState),  32'(BR_IDLE));
    chk("rst_req",   32'(data_req),  32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    tick();
    resetn = 1'b1;

    // Zero-wait word load.
    tick();
    access(4'b0000, 2'd2, 32'h8000_1000, 32'h0);
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #2;
    chk("zw_req",   32'(data_req),  32'd1);
    chk("zw_stall", 32'(cpu_stall), 32'd0);
    chk("zw_rdata", cpu_rdata,      32'hDEAD_BEEF);
    chk("zw_size",  32'(data_size), 32'd2);
    tick();
    idleInputs();
    #2;
    chk("zw_req_drop", 32'(data_req), 32'd0);

    // Zero-wait accesses over the size encodings.
    for (int i = 0; i < 5; i++) begin
      tick();
      access(vecWen[i], vecRsize[i], 32'h100 + 32'(i * 4), $urandom);
      data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = $urandom;
      #2;
      chk("vec_size",  32'(data_size), 32'(vecSize[i]));
      chk("vec_wr",    32'(data_wr),   32'(vecWen[i] != 4'b0000));
      chk("vec_stall", 32'(cpu_stall), 32'd0);
      tick();
      idleInputs();
    end

    // Delayed half store: addr_ok on the third cycle, data_ok three later.
    tick();
    access(4'b1100, 2'd0, 32'h0000_1002, 32'hAABB_CCDD);
    stallCnt = 0;
    #2;
    chk("st_wr",   32'(data_wr),   32'd1);
    chk("st_size", 32'(data_size), 32'd1);
    if (cpu_stall) stallCnt++;
    for (int c = 1; c <= 5; c++) begin
      tick();
      cpu_addr = 32'hFFFF_FFF0; cpu_wdata = $urandom; cpu_wen = 4'b1111;
      data_addr_ok = (c == 2); data_data_ok = (c == 5);
      #2;
      if (c <= 2) begin
        chk("st_hold_req",   32'(data_req),  32'd1);
        chk("st_hold_addr",  data_addr,      32'h0000_1002);
        chk("st_hold_wdata", data_wdata,     32'hAABB_CCDD);
        chk("st_hold_size",  32'(data_size), 32'd1);
        chk("st_hold_wr",    32'(data_wr),   32'd1);
      end
      if (cpu_stall) stallCnt++;
    end
    chk("st_stall_last", 32'(cpu_stall), 32'd0);
    chk("st_stall_cnt",  32'(stallCnt),  32'd5);
    tick();
    idleInputs();

    // Load completing under another stall source.
    tick();
    access(4'b0000, 2'd2, 32'h0000_2000, 32'h0);
    data_addr_ok = 1'b1;
    #2;
    chk("os_stall0", 32'(cpu_stall), 32'd1);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678; cpu_other_stall = 1'b1;
    #2;
    chk("os_stall1", 32'(cpu_stall), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      data_data_ok = 1'b0; data_rdata = 32'h0;
      #2;
      chk("os_state", 32'(dbgState),  32'(BR_DONE));
      chk("os_rdata", cpu_rdata,      32'h1234_5678);
      chk("os_noreq", 32'(data_req),  32'd0);
      chk("os_stall", 32'(cpu_stall), 32'd0);
    end
    tick();
    cpu_other_stall = 1'b0;
    #2;
    chk("os_last_rdata", cpu_rdata, 32'h1234_5678);
    tick();
    idleInputs();
    #2;
    chk("os_idle", 32'(dbgState), 32'(BR_IDLE));

    // Kill before issue.
    tick();
    access(4'b0000, 2'd2, 32'h0000_2004, 32'h0);
    cpu_kill = 1'b1; data_addr_ok = 1'b1;
    #2;
    chk("kb_req",   32'(data_req),  32'd0);
    chk("kb_stall", 32'(cpu_stall), 32'd0);
    tick();
    idleInputs();
    #2;
    chk("kb_state", 32'(dbgState), 32'(BR_IDLE));

    // Kill after issue: the outstanding byte load still completes.
    tick();
    access(4'b0000, 2'd0, 32'h0000_3001, 32'h0);
    tick();
    cpu_kill = 1'b1;
    #2;
    chk("ka_req",   32'(data_req),  32'd1);
    chk("ka_stall", 32'(cpu_stall), 32'd1);
    chk("ka_addr",  data_addr,      32'h0000_3001);
    tick();
    data_addr_ok = 1'b1;
    #2;
    chk("ka_req_acc", 32'(data_req), 32'd1);
    tick();
    data_addr_ok = 1'b0;
    #2;
    chk("ka_wait_req",   32'(data_req),  32'd0);
    chk("ka_wait_stall", 32'(cpu_stall), 32'd1);
    tick();
    data_data_ok = 1'b1; data_rdata = 32'h0000_0055;
    #2;
    chk("ka_done_stall", 32'(cpu_stall), 32'd0);
    chk("ka_rdata",      cpu_rdata,      32'h0000_0055);
    tick();
    idleInputs();
    #2;
    chk("ka_idle", 32'(dbgState), 32'(BR_IDLE));

    // Byte store accepted with data in REQ while another stall is active.
    tick();
    access(4'b0001, 2'd0, 32'h0000_4003, 32'h0000_00A5);
    tick();
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; cpu_other_stall = 1'b1;
    #2;
    chk("rd_stall", 32'(cpu_stall), 32'd1);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0; cpu_other_stall = 1'b0;
    #2;
    chk("rd_state", 32'(dbgState), 32'(BR_DONE));
    chk("rd_rdata", cpu_rdata,     32'hCAFE_F00D);
    tick();
    idleInputs();
    #2;
    chk("rd_idle", 32'(dbgState), 32'(BR_IDLE));

    // Reset while waiting for data; later data_ok is stray.
    tick();
    access(4'b0000, 2'd2, 32'h0000_5000, 32'h0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    #2;
    chk("rw_wait", 32'(dbgState), 32'(BR_WAIT));
    tick();
    resetn = 1'b0;
    #2;
    chk("rw_rst_stall", 32'(cpu_stall), 32'd0);
    chk("rw_rst_req",   32'(data_req),  32'd0);
    tick();
    resetn = 1'b1; cpu_en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_0BAD;
    #2;
    chk("rw_state", 32'(dbgState),  32'(BR_IDLE));
    chk("rw_req",   32'(data_req),  32'd0);
    chk("rw_stall", 32'(cpu_stall), 32'd0);
    tick();
    #2;
    chk("rw_stray_state", 32'(dbgState),  32'(BR_IDLE));
    chk("rw_stray_stall", 32'(cpu_stall), 32'd0);
    tick();
    idleInputs();
    tick();

    // ---------------- final report ----------------
    simDone = 1'b1;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
